// File: rtl/rf_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rf_pkg
// Description : Shared register-file constants and types for the write-port
//               arbiter and its scoreboard.
//               XLEN       - data width of a register
//               NUM_REGS   - number of architectural registers
//               REG_ADDR_W - width of a register index
//               addr_onehot() - register index to one-hot register mask
// Revision    : 1.0 - initial release
// ============================================================================
package rf_pkg;

    localparam int XLEN       = 32;
    localparam int NUM_REGS   = 32;
    localparam int REG_ADDR_W = 5;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [XLEN-1:0]       reg_data_t;

    // One-hot mask with a single bit set at the given register index.
    function automatic logic [NUM_REGS-1:0] addr_onehot(input reg_addr_t addr);
        return NUM_REGS'(1) << addr;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rf_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : rf_scoreboard
// Description : Busy scoreboard tracking destinations with an outstanding
//               long-latency result. Bit 0 (x0) is never set.
// Ports       : clk, rst            - clock, synchronous active-high reset
//               set_en / set_addr   - mark a destination busy (accepted issue)
//               clr_en / clr_addr   - retire a destination (accepted B write)
//               rs1, rs2, rd        - decode lookups -> busy_rs1/2/rd
//                                     (registered state, no same-cycle clear)
//               iss_rd -> iss_ready - issue lookup; a destination retiring
//                                     this cycle counts as free
// Revision    : 1.0 - initial release
// ============================================================================
module rf_scoreboard
    import rf_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      set_en,
    input  reg_addr_t set_addr,
    input  logic      clr_en,
    input  reg_addr_t clr_addr,
    input  reg_addr_t rs1,
    input  reg_addr_t rs2,
    input  reg_addr_t rd,
    input  reg_addr_t iss_rd,
    output logic      busy_rs1,
    output logic      busy_rs2,
    output logic      busy_rd,
    output logic      iss_ready
);

    logic [NUM_REGS-1:0] r_busy;
    logic [NUM_REGS-1:0] w_clr_mask;
    logic [NUM_REGS-1:0] w_set_mask;
    logic [NUM_REGS-1:0] w_busy_eff;

    assign w_clr_mask = clr_en ? addr_onehot(clr_addr) : '0;
    assign w_set_mask = set_en ? addr_onehot(set_addr) : '0;

    // Busy view with this cycle's retirement already applied.
    assign w_busy_eff = r_busy & ~w_clr_mask;

    assign iss_ready = ~w_busy_eff[iss_rd];
    assign busy_rs1  = r_busy[rs1];
    assign busy_rs2  = r_busy[rs2];
    assign busy_rd   = r_busy[rd];

    // Set is applied after clear so a same-cycle retire+issue to one rd
    // leaves the bit set; bit 0 is forced low.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy <= '0;
        end else begin
            r_busy <= (w_busy_eff | w_set_mask) & ~NUM_REGS'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/rf_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rf_wb_arbiter
// Description : Register-file write-port controller. Shares the single write
//               port between the core writeback path (A) and a long-latency
//               unit (B), tracks B destinations in a busy scoreboard and
//               stalls the core on RAW/WAW hazards against them.
//               Optional macro RF_WB_FAIRNESS_EN: after MAX_WAIT denied
//               cycles of a valid B result, force one core stall so B wins.
// Ports       : clk, rst                 - clock, sync active-high reset
//               a_we/a_rd/a_data         - core writeback request
//               b_valid/b_rd/b_data      - source B result, b_ready accept
//               iss_valid/iss_rd         - issue to B, iss_ready accept
//               dec_rs1/dec_rs2/dec_rd   - current instruction fields
//               core_stall               - hold current instruction
//               rf_we/rf_waddr/rf_wdata  - register-file write port
// Revision    : 1.0 - initial release
// ============================================================================
module rf_wb_arbiter
    import rf_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            a_we,
    input  reg_addr_t       a_rd,
    input  logic [XLEN-1:0] a_data,
    input  logic            b_valid,
    input  reg_addr_t       b_rd,
    input  logic [XLEN-1:0] b_data,
    output logic            b_ready,
    input  logic            iss_valid,
    input  reg_addr_t       iss_rd,
    output logic            iss_ready,
    input  reg_addr_t       dec_rs1,
    input  reg_addr_t       dec_rs2,
    input  reg_addr_t       dec_rd,
    output logic            core_stall,
    output logic            rf_we,
    output reg_addr_t       rf_waddr,
    output logic [XLEN-1:0] rf_wdata
);

    logic w_busy_rs1;
    logic w_busy_rs2;
    logic w_busy_rd;
    logic w_sb_iss_ready;
    logic w_hz;
    logic w_force;
    logic w_a_go;
    logic w_b_go;
    logic w_iss_fire;

    rf_scoreboard u_scoreboard (
        .clk       (clk),
        .rst       (rst),
        .set_en    (w_iss_fire),
        .set_addr  (iss_rd),
        .clr_en    (w_b_go),
        .clr_addr  (b_rd),
        .rs1       (dec_rs1),
        .rs2       (dec_rs2),
        .rd        (dec_rd),
        .iss_rd    (iss_rd),
        .busy_rs1  (w_busy_rs1),
        .busy_rs2  (w_busy_rs2),
        .busy_rd   (w_busy_rd),
        .iss_ready (w_sb_iss_ready)
    );

    // Hazards use registered busy only: there is no bypass of B data, so a
    // dependent instruction stalls through the cycle B writes.
    assign w_hz       = w_busy_rs1 | w_busy_rs2 | w_busy_rd;
    assign core_stall = rst | w_hz | w_force;

    // A write to x0 is not a write, leaving the port free for B.
    assign w_a_go     = a_we && (a_rd != '0) && !core_stall;
    assign b_ready    = !rst && b_valid && !w_a_go;
    assign w_b_go     = b_valid && b_ready;

    assign iss_ready  = !rst && w_sb_iss_ready;
    assign w_iss_fire = iss_valid && iss_ready;

    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = '0;
        rf_wdata = '0;
        if (w_a_go) begin
            rf_we    = 1'b1;
            rf_waddr = a_rd;
            rf_wdata = a_data;
        end else if (w_b_go) begin
            rf_we    = 1'b1;
            rf_waddr = b_rd;
            rf_wdata = b_data;
        end
    end

`ifdef RF_WB_FAIRNESS_EN
    localparam int c_CNT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [c_CNT_W-1:0] c_MAX = c_CNT_W'(MAX_WAIT);

    logic [c_CNT_W-1:0] r_wait_cnt;
    logic [c_CNT_W-1:0] w_cnt_next;
    logic               r_force;

    // Counter saturates at MAX_WAIT; any B grant restarts it.
    always_comb begin
        w_cnt_next = r_wait_cnt;
        if (w_b_go) begin
            w_cnt_next = '0;
        end else if (b_valid && (r_wait_cnt != c_MAX)) begin
            w_cnt_next = r_wait_cnt + 1'b1;
        end
    end

    // Force is raised on the edge where the count reaches MAX_WAIT, so B is
    // denied exactly MAX_WAIT cycles and then wins the next one.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wait_cnt <= '0;
            r_force    <= 1'b0;
        end else begin
            r_wait_cnt <= w_cnt_next;
            r_force    <= (w_cnt_next == c_MAX) && (r_wait_cnt != c_MAX);
        end
    end

    assign w_force = r_force;
`else
    logic w_unused_max_wait;

    // Strict A priority: B only takes cycles without an effective A write.
    assign w_force           = 1'b0;
    assign w_unused_max_wait = ^MAX_WAIT;
`endif

endmodule
`default_nettype wire

// File: doc/rf_wb_arbiter.md
# rf_wb_arbiter

Write-port controller for the 32×32 register file. It shares the single write port (`rsW`/`dataW`/`RegWEn`) between the core's single-cycle writeback path (source A) and a long-latency unit such as mul/div or a multi-cycle load (source B). It also keeps a 32-entry busy scoreboard of destinations with outstanding source-B results, and stalls the core on RAW/WAW hazards. It sits between decode/writeback and `reg_file`, and directly drives the register file's write inputs.

## Interface
- `XLEN`, 32, data width.
- `MAX_WAIT`, 4, cycles source B may be denied before a forced grant (used only with the fairness feature).
- `clk` input 1: single clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `a_we` input 1: core writeback request this cycle.
- `a_rd` input 5: core destination.
- `a_data` input XLEN: core writeback data.
- `b_valid` input 1: source B result valid.
- `b_rd` input 5: source B destination.
- `b_data` input XLEN: source B data.
- `b_ready` output 1: source B result accepted this cycle.
- `iss_valid` input 1: core issuing an op to source B.
- `iss_rd` input 5: destination of the issued op.
- `iss_ready` output 1: issue accepted.
- `dec_rs1`, `dec_rs2`, `dec_rd` input 5 each: current instruction fields. Decode drives 0 for unused fields.
- `core_stall` output 1: the core must hold the current instruction; it does not commit.
- `rf_we` output 1: drives `RegWEn`.
- `rf_waddr` output 5: drives `rsW`.
- `rf_wdata` output XLEN: drives `dataW`.

## Operation
- Scoreboard `busy[31:0]`: bit 0 is hardwired 0.
  - Set on an accepted issue (`iss_valid && iss_ready`, `iss_rd != 0`).
  - Cleared on an accepted B write (`b_valid && b_ready`).
- `iss_ready = !busy_eff[iss_rd]`, where `busy_eff = busy & ~clear_this_cycle`. An issue to the rd being retired in the same cycle is accepted, and the bit ends up set.
- Hazard stall: `hz = busy[dec_rs1] | busy[dec_rs2] | busy[dec_rd]`, using registered busy. There is no bypass from B's data.
- `core_stall = hz | force`.
- Grant:
  - A effective write: `a_go = a_we && a_rd != 0 && !core_stall`.
  - When `a_go` is set, the port carries A and `b_ready = 0`.
  - Otherwise `b_ready = b_valid` and the port carries B.
  - When neither source writes, `rf_we = 0`, `rf_waddr = 0`, `rf_wdata = 0`.
- A write to x0 is not a write, so B may take the port that cycle.
- B must hold `b_rd`/`b_data` stable while `b_valid && !b_ready`.
- An A-vs-B same-rd collision is impossible: `busy[b_rd]` is set, so an A instruction targeting it is stalled by the WAW check.

## Timing
- Write-port outputs are combinational from the inputs; the register file write lands at the same rising edge (zero added latency).
- Scoreboard set/clear becomes visible the cycle after the event. A dependent instruction stalls through the cycle in which B writes, and proceeds the next cycle.
- `iss_ready`, `b_ready` and `core_stall` are combinational from inputs and registered state.
- Reset values: `busy = 0`, wait counter `= 0`, `force = 0`. During reset, outputs are `rf_we = 0`, `b_ready = 0`, `iss_ready = 0`, `core_stall = 1`.
- Reset mid-operation discards all pending scoreboard entries. Source B must be reset by the same `rst`.

## Configuration
- `RF_WB_FAIRNESS_EN` defined:
  - A counter increments each cycle with `b_valid && !b_ready`.
  - When it equals `MAX_WAIT`, `force` is registered high for exactly one cycle. That cycle raises `core_stall`, which yields `a_go = 0` and grants B.
  - The counter clears on any B grant.
- `RF_WB_FAIRNESS_EN` undefined:
  - `force` is tied 0 and no counter is built.
  - A has strict priority, and B is granted only on cycles without an effective A write.

## Structure
- Shared package `rf_pkg`:
  - constants `XLEN = 32`, `NUM_REGS = 32`, `REG_ADDR_W = 5`;
  - typedef `reg_addr_t` (logic [4:0]);
  - typedef `reg_data_t` (logic [XLEN-1:0]).
- One sub-module, `rf_scoreboard`:
  - holds the busy vector;
  - takes set/clear ports;
  - provides three combinational lookups (rs1, rs2, rd) plus `iss_ready`.
- The grant mux and fairness counter live in the top.

## Test plan
- Reset, then `a_we=1, a_rd=5, a_data=0x11` → `rf_we=1, rf_waddr=5, rf_wdata=0x11` in the same cycle, `b_ready=0`.
- Issue `iss_rd=7`, next cycle `dec_rs1=7` → `core_stall=1`. B returns `b_rd=7, b_data=0xABCD` → `b_ready=1`, port writes x7. The following cycle `core_stall=0`.
- `a_we=1, a_rd=0` with `b_valid=1, b_rd=3` → `b_ready=1`, port writes x3. Issue to rd=3 in the same cycle → `iss_ready=1`, `busy[3]=1` afterwards.
- `iss_rd=9` while `busy[9]=1` and no B retire → `iss_ready=0`. `iss_rd=0` → accepted, scoreboard unchanged.
- Fairness on, `MAX_WAIT=4`: A writes x1..x6 every cycle with B valid → B is denied 4 cycles, then `core_stall=1` for one cycle while B is granted, and A resumes. Fairness off → B waits until A idles.
- Assert `rst` with `busy[12]=1` → next cycle `busy=0`, `dec_rs2=12` gives `core_stall=0`.
